// File: rtl/call_arbiter.sv
// Round-robin arbiter sharing one start/done function unit among NREQ requesters.
// Optional WAIT timeout abort is enabled by defining CALL_ARB_TIMEOUT_EN.
module call_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_result,
  output logic [NREQ-1:0]   resp_err,
  output logic              busy,
  output logic              f_start,
  output logic [31:0]       f_a,
  output logic [31:0]       f_b,
  input  logic [31:0]       f_result,
  input  logic              f_done
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ARM, WAIT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [DW-1:0] a_arr [NREQ];
  logic [DW-1:0] b_arr [NREQ];
  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] nxt_ptr;
  int unsigned   j;

`ifdef CALL_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[DW*g +: DW];
    assign b_arr[g] = req_b[DW*g +: DW];
  end

  // First pending requester at or after ptr, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[IW'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
    nxt_ptr = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      f_start     <= 1'b0;
      f_a         <= '0;
      f_b         <= '0;
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_err    <= '0;
      busy        <= 1'b0;
`ifdef CALL_ARB_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      f_start    <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_err   <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            owner     <= gnt_idx;
            f_a       <= a_arr[gnt_idx];
            f_b       <= b_arr[gnt_idx];
            ptr       <= nxt_ptr;
            f_start   <= 1'b1;
            req_ready <= NREQ'(1) << gnt_idx;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= ARM;
        // Previous call's done may still be high here, so it is not looked at.
        ARM: begin
          state <= WAIT;
`ifdef CALL_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (f_done) begin
            resp_result <= f_result;
            resp_valid  <= NREQ'(1) << owner;
            busy        <= 1'b0;
            state       <= IDLE;
          end
`ifdef CALL_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_err <= NREQ'(1) << owner;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_call_arbiter.sv
// Directed self-checking bench for call_arbiter with a 2-cycle-latency callee model.
// Honors CALL_ARB_TIMEOUT_EN the same way as the design.
module tb_call_arbiter;

  localparam int unsigned NREQ = 4;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_result;
  logic [NREQ-1:0]   resp_err;
  logic              busy;
  logic              f_start;
  logic [31:0]       f_a;
  logic [31:0]       f_b;
  logic [31:0]       f_result;
  logic              f_done;

  int errors;
  int checks;
  int cyc;
  logic hang;

  call_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy),
    .f_start(f_start), .f_a(f_a), .f_b(f_b),
    .f_result(f_result), .f_done(f_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Callee: samples a the cycle after start, drops done then, raises done one cycle later.
  logic        s1, s2;
  logic [31:0] a_lat;
  always @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0; s2 <= 1'b0; f_done <= 1'b0; f_result <= '0; a_lat <= '0;
    end else begin
      s1 <= f_start;
      s2 <= s1;
      if (s1) begin
        f_done <= 1'b0;
        a_lat  <= f_a;
      end else if (s2 && !hang) begin
        f_done   <= 1'b1;
        f_result <= a_lat;
      end
    end
  end

  task step;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task test_reset;
    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; hang = 1'b0;
    step; step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (f_start !== 1'b0) begin errors++; $display("FAIL reset_f_start got=%0b want=0", f_start); end
    checks++; if (req_ready !== 4'b0 || resp_valid !== 4'b0 || resp_err !== 4'b0) begin
      errors++; $display("FAIL reset_vectors ready=%b valid=%b err=%b want=0", req_ready, resp_valid, resp_err);
    end
    checks++; if (resp_result !== 32'd0 || f_a !== 32'd0 || f_b !== 32'd0) begin
      errors++; $display("FAIL reset_data result=%0d f_a=%0d f_b=%0d want=0", resp_result, f_a, f_b);
    end
    reset_n = 1'b1;
  endtask

  task test_fairness;
    int          exp_who [5];
    logic [31:0] exp_a [5];
    logic        got;
    exp_who = '{0, 1, 2, 3, 0};
    exp_a   = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
    req_a = {32'd13, 32'd12, 32'd11, 32'd10};
    req_b = {32'd103, 32'd102, 32'd101, 32'd100};
    req_valid = 4'b0111;
    for (int n = 0; n < 5; n++) begin
      if (n == 3) req_valid = 4'b1111;
      got = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step;
        if (req_ready !== 4'b0) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL fair_ready_timeout call=%0d got=none want=%0d", n, exp_who[n]);
      end else begin
        checks++; if (req_ready !== (4'(1) << exp_who[n])) begin
          errors++; $display("FAIL fair_grant call=%0d got=%b want=%b", n, req_ready, 4'(1) << exp_who[n]);
        end
        checks++; if (f_a !== exp_a[n] || f_b !== exp_a[n] + 32'd90) begin
          errors++; $display("FAIL fair_operands call=%0d f_a=%0d f_b=%0d want=%0d,%0d", n, f_a, f_b, exp_a[n], exp_a[n] + 32'd90);
        end
        req_valid = req_valid & ~req_ready;
        for (int d = 1; d <= 4; d++) begin
          step;
          checks++;
          if (d < 4) begin
            if (resp_valid !== 4'b0) begin
              errors++; $display("FAIL fair_early_resp call=%0d d=%0d got=%b want=0", n, d, resp_valid);
            end
          end else if (resp_valid !== (4'(1) << exp_who[n]) || resp_result !== exp_a[n]) begin
            errors++; $display("FAIL fair_resp call=%0d valid=%b result=%0d want=%b,%0d",
                               n, resp_valid, resp_result, 4'(1) << exp_who[n], exp_a[n]);
          end
        end
      end
    end
    req_valid = '0;
    step;
  endtask

  task test_single;
    req_a = '0; req_b = '0;
    req_a[31:0] = 32'd5; req_b[31:0] = 32'd9;
    req_valid = 4'b0001;
    step;
    checks++; if (req_ready !== 4'b0001 || f_start !== 1'b1) begin
      errors++; $display("FAIL single_issue ready=%b start=%0b want=0001,1", req_ready, f_start);
    end
    checks++; if (f_a !== 32'd5 || f_b !== 32'd9) begin
      errors++; $display("FAIL single_operands f_a=%0d f_b=%0d want=5,9", f_a, f_b);
    end
    req_valid = '0;
    for (int c = 2; c <= 4; c++) begin
      step;
      checks++; if (f_start !== 1'b0 || f_a !== 32'd5 || resp_valid !== 4'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL single_wait cyc=%0d start=%0b f_a=%0d valid=%b busy=%0b want=0,5,0,1",
                           c, f_start, f_a, resp_valid, busy);
      end
    end
    step;
    checks++; if (resp_valid !== 4'b0001 || resp_result !== 32'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL single_resp valid=%b result=%0d busy=%0b want=0001,5,0", resp_valid, resp_result, busy);
    end
  endtask

  task test_reset_mid_call;
    req_a = {32'd23, 32'd22, 32'd21, 32'd20};
    req_b = '0;
    req_valid = 4'b0100;
    step;
    checks++; if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL midrst_grant got=%b want=0100", req_ready);
    end
    req_valid = '0;
    step; step;
    reset_n = 1'b0;
    step;
    checks++; if (busy !== 1'b0 || f_start !== 1'b0 || req_ready !== 4'b0 || resp_valid !== 4'b0 || resp_err !== 4'b0) begin
      errors++; $display("FAIL midrst_ctrl busy=%0b start=%0b ready=%b valid=%b err=%b want=0",
                         busy, f_start, req_ready, resp_valid, resp_err);
    end
    checks++; if (f_a !== 32'd0 || f_b !== 32'd0 || resp_result !== 32'd0) begin
      errors++; $display("FAIL midrst_data f_a=%0d f_b=%0d result=%0d want=0", f_a, f_b, resp_result);
    end
    reset_n = 1'b1;
    req_valid = 4'b1010;
    step;
    checks++; if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_ptr0 got=%b want=0010", req_ready);
    end
    req_valid = 4'b1000;
    step; step; step;
    checks++; if (resp_valid !== 4'b0) begin
      errors++; $display("FAIL midrst_stale_resp got=%b want=0", resp_valid);
    end
    step;
    checks++; if (resp_valid !== 4'b0010 || resp_result !== 32'd21) begin
      errors++; $display("FAIL midrst_resp1 valid=%b result=%0d want=0010,21", resp_valid, resp_result);
    end
    step;
    checks++; if (req_ready !== 4'b1000 || f_a !== 32'd23) begin
      errors++; $display("FAIL midrst_grant3 ready=%b f_a=%0d want=1000,23", req_ready, f_a);
    end
    req_valid = '0;
    step; step; step; step;
    checks++; if (resp_valid !== 4'b1000 || resp_result !== 32'd23) begin
      errors++; $display("FAIL midrst_resp3 valid=%b result=%0d want=1000,23", resp_valid, resp_result);
    end
  endtask

  task test_hang;
    int bad;
    hang = 1'b1;
    req_a = '0; req_a[31:0] = 32'd7;
    req_valid = 4'b0001;
    step;
    checks++; if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL hang_grant got=%b want=0001", req_ready);
    end
    req_valid = '0;
`ifdef CALL_ARB_TIMEOUT_EN
    bad = 0;
    for (int c = 2; c <= 18; c++) begin
      step;
      if (busy !== 1'b1 || resp_err !== 4'b0 || resp_valid !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL tmo_early bad_cycles=%0d want=0", bad);
    end
    step;
    checks++; if (resp_err !== 4'b0001 || busy !== 1'b0 || resp_valid !== 4'b0 || resp_result !== 32'd23) begin
      errors++; $display("FAIL tmo_abort err=%b busy=%0b valid=%b result=%0d want=0001,0,0,23",
                         resp_err, busy, resp_valid, resp_result);
    end
    step;
    checks++; if (resp_err !== 4'b0) begin
      errors++; $display("FAIL tmo_pulse got=%b want=0", resp_err);
    end
`else
    bad = 0;
    for (int c = 2; c <= 41; c++) begin
      step;
      if (busy !== 1'b1 || resp_err !== 4'b0 || resp_valid !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL hang_busy bad_cycles=%0d want=0", bad);
    end
    checks++; if (resp_result !== 32'd23) begin
      errors++; $display("FAIL hang_result got=%0d want=23", resp_result);
    end
`endif
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    hang = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    test_reset;
    test_fairness;
    test_single;
    test_reset_mid_call;
    test_hang;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/call_arbiter.md
# call_arbiter

Round-robin arbiter that shares a single start/done function unit (32-bit `a`, `b` in, 32-bit `result` out) among `NREQ` requesters. It owns the callee's `start`/`a`/`b` inputs, sequences one call at a time, masks the callee's stale level-held `done`, and routes `result` back to the granted requester. It sits between the requesting FSMs and one instance of the generated function module.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be at least 1.
- `TIMEOUT`, 16: maximum number of WAIT cycles before abort. Used only when `CALL_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in NREQ: request level per requester. Must be held until `req_ready[i]` is seen.
- `req_a` in NREQ*32: operand a, packed; requester i uses bits [32i+31:32i].
- `req_b` in NREQ*32: operand b, packed the same way as `req_a`.
- `req_ready` out NREQ: one-hot, one-cycle pulse when requester i's operands are taken.
- `resp_valid` out NREQ: one-hot, one-cycle pulse to the owner when its result is ready.
- `resp_result` out 32: result of the last completed call; held until the next completion.
- `resp_err` out NREQ: one-cycle timeout pulse. Constant 0 without the macro.
- `busy` out 1: high whenever state is not IDLE.
- `f_start` out 1, `f_a` out 32, `f_b` out 32: drive the callee.
- `f_result` in 32, `f_done` in 1: from the callee. `f_done` is level-held by the callee until its next call.

## Operation
- FSM states: IDLE, ISSUE, ARM, WAIT.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit at or after pointer `ptr`, searching upward and wrapping at NREQ.
  - On the grant edge: latch `owner` = granted index, latch its `req_a`/`req_b` into `f_a`/`f_b`, set `ptr` = (owner+1) mod NREQ, go to ISSUE.
- **ISSUE** (1 cycle)
  - `f_start`=1 and `req_ready[owner]`=1.
  - Go to ARM.
- **ARM** (1 cycle)
  - `f_start`=0; `f_done` is ignored, because the previous call's done may still be high.
  - Go to WAIT.
- **WAIT**
  - On `f_done`=1: next edge sets `resp_result` <= `f_result` and `resp_valid[owner]`=1 for one cycle, then go to IDLE.
- `f_a`/`f_b` stay stable from ISSUE until the next grant. The callee samples them in the cycle after `start`.
- `req_valid` bits of non-granted requesters are left pending; no request is dropped.
- Reset (`reset_n`=0 on an edge), including mid-call:
  - state → IDLE, `ptr` → 0, `owner` → 0.
  - All outputs → 0: `f_start`, `f_a`, `f_b`, `req_ready`, `resp_valid`, `resp_result`, `resp_err`, `busy`.
  - The in-flight call is abandoned with no response. The callee is reset by its own reset.

## Timing
- Cycle 0: IDLE with a request present.
- Cycle 1: ISSUE.
- Cycle 2: ARM.
- Cycle 3: WAIT; `f_done`=0.
- Cycle 4: WAIT; `f_done`=1 from a callee with 2-cycle call latency.
- Cycle 5: `resp_valid` pulse, state IDLE. A new grant can be made in the same cycle.
- Latency from request to response is 5 cycles with that callee; throughput is one call per 5 cycles back-to-back.
- `req_ready` arrives 1 cycle after the grant edge. Requesters deassert `req_valid` the cycle after `req_ready`. Re-arbitration cannot occur earlier than 4 cycles later, so no double issue is possible.
- `resp_valid` and `req_ready` may both be high in the same cycle only for different phases of different calls; they never overlap for one call.

## Configuration
- `CALL_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without `f_done`.
  - When it reaches `TIMEOUT`, the next edge pulses `resp_err[owner]` for one cycle and returns to IDLE. `resp_valid` is not pulsed and `resp_result` is unchanged.
  - If `f_done` and expiry occur in the same cycle, done wins.
- Not defined: no counter; WAIT waits indefinitely; `resp_err` is tied to 0.

## Test plan
- Single request: req 0 with a=5, b=9 at cycle 0 → `req_ready[0]` and `f_start` at cycle 1; `f_a`=5 at cycles 1-4; `resp_valid[0]` at cycle 5 with `resp_result`=5.
- Fairness, NREQ=4: requesters 0, 1 and 2 held with a=10, 11, 12 → grant order 0, 1, 2 with results 10, 11, 12. Then all four asserted → next grant is 3, then 0.
- Stale done: callee `done` is still 1 from the prior call at the second ISSUE/ARM → no early completion; `resp_valid` comes exactly 4 cycles after `req_ready`.
- Reset mid-call: `reset_n`=0 at cycle 3 → next cycle all outputs are 0, no `resp_valid`; after release the next grant goes to the lowest pending index (`ptr`=0).
- Timeout, with the macro and TIMEOUT=16: callee model never raises done → `resp_err[owner]` pulses after 16 WAIT cycles, `busy` drops, `resp_result` is unchanged. Without the macro, `busy` stays 1 indefinitely.
